// File: rtl/dig_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dig_pkg : shared constants and helpers for the dig hub scheduler.  Rev 1.0
// -----------------------------------------------------------------------------
package dig_pkg;

    localparam int MAX_COGS  = 16;
    localparam int MAX_IDX_W = $clog2(MAX_COGS);

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_COGS-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_COGS; i++) begin
            if (oh[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dig_rr_next.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dig_rr_next : circular priority search for the next requesting cog.  Rev 1.0
// -----------------------------------------------------------------------------
module dig_rr_next
    import dig_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] cur_onehot,
    input  logic         valid,
    output logic [N-1:0] next_onehot,
    output logic         none
);

    int   start;
    logic found;

    // Two passes: indices at/after start first, then the wrapped-around part,
    // which places the current owner itself last in the priority order.
    always_comb begin
        start = valid ? int'(onehot_to_idx(MAX_COGS'(cur_onehot))) + 1 : 0;
        if (start >= N) begin
            start = 0;
        end
        next_onehot = '0;
        found       = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= start)) begin
                next_onehot[j] = 1'b1;
                found          = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < start)) begin
                next_onehot[j] = 1'b1;
                found          = 1'b1;
            end
        end
        none = !found;
    end

endmodule
`default_nettype wire

// File: rtl/dig_slot_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// dig_slot_sched : hub time-slot scheduler and free-running system counter.  Rev 1.0
// -----------------------------------------------------------------------------
module dig_slot_sched
    import dig_pkg::*;
#(
    parameter  int NUMCOGS   = 8,
    parameter  int SLOT_CLKS = 2,
    parameter  int CNT_W     = 32,
    parameter  int SKIP_IDLE = 0,
    localparam int IDX_W     = clog2_min1(NUMCOGS)
) (
    input  logic               clk_cog,
    input  logic               res,
    input  logic [NUMCOGS-1:0] cog_ena,
    output logic [CNT_W-1:0]   cnt,
    output logic               ena_bus,
    output logic [NUMCOGS-1:0] bus_sel,
    output logic [IDX_W-1:0]   slot_idx,
    output logic               bus_wrap
);

    localparam int PH_W = clog2_min1(SLOT_CLKS);

    logic [PH_W-1:0]    phase;
    logic [PH_W-1:0]    phase_next;
    logic [NUMCOGS-1:0] req;
    logic [NUMCOGS-1:0] next_oh;
    logic               next_none;
    logic [IDX_W-1:0]   next_idx;
    logic               cur_valid;

    assign phase_next = (phase == PH_W'(SLOT_CLKS - 1)) ? '0 : phase + PH_W'(1);
    assign cur_valid  = |bus_sel;

    // Plain rotation is a priority search with every cog requesting.
    generate
        if (SKIP_IDLE != 0) begin : g_skip
            assign req = cog_ena;
        end else begin : g_rotate
            assign req = cog_ena | {NUMCOGS{1'b1}};
        end
    endgenerate

    dig_rr_next #(
        .N (NUMCOGS)
    ) u_rr_next (
        .req         (req),
        .cur_onehot  (bus_sel),
        .valid       (cur_valid),
        .next_onehot (next_oh),
        .none        (next_none)
    );

    assign next_idx = IDX_W'(onehot_to_idx(MAX_COGS'(next_oh)));

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            cnt      <= '0;
            phase    <= '0;
            ena_bus  <= 1'b0;
            bus_sel  <= '0;
            slot_idx <= '0;
            bus_wrap <= 1'b0;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            phase   <= phase_next;
            ena_bus <= (phase_next == PH_W'(SLOT_CLKS - 1));
            if (ena_bus) begin
                bus_sel  <= next_none ? '0 : next_oh;
                slot_idx <= next_none ? '0 : next_idx;
                // A wrap needs a real owner on both sides of the update.
                bus_wrap <= cur_valid && !next_none && (next_idx <= slot_idx);
            end else begin
                bus_wrap <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
